uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue and issue controller that sits directly upstream of the UART transmitter.
- Producers (game logic, score formatter) push bytes at any rate into an internal FIFO.
- The controller pops one byte at a time, launches it with a single-cycle valid pulse, and waits for the transmitter's completion handshake before launching the next.
- Decouples bursty message generation from the slow serial line.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- COUNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- systemClock  input  1  single clock for the whole block
- systemResetN  input  1  reset, asynchronous assert, active-low
- writeEnable  input  1  push writeByte this cycle
- writeByte  input  8  byte to enqueue
- clearOverflow  input  1  clears overflowError
- fifoFull  output  1  count == DEPTH
- fifoEmpty  output  1  count == 0
- fifoCount  output  COUNT_W  current occupancy
- overflowError  output  1  sticky: a push was dropped
- queueBusy  output  1  FIFO non-empty or issue FSM not IDLE
- txDataValid  output  1  one-cycle launch pulse to the transmitter
- txByte  output  8  byte presented with txDataValid; held until the next launch
- txActive  input  1  transmitter busy (status only; not used for sequencing)
- txDone  input  1  transmitter completion flag, high for one or more cycles per byte

Behaviour:
- Reset (systemResetN=0, async): count=0, read and write pointers=0, FSM=IDLE, txDataValid=0, txByte=8'h00, overflowError=0, fifoEmpty=1, fifoFull=0, queueBusy=0. Reset mid-frame discards queued bytes; any byte already launched completes in the transmitter and its txDone is ignored.
- FIFO:
  - Circular buffer with pointers of width $clog2(DEPTH) that wrap naturally.
  - Push accepted iff writeEnable=1 and fifoFull=0, both evaluated on registered state.
  - Push while full: byte dropped, overflowError<=1, even if a pop occurs in the same cycle.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Flags and fifoCount are registered-state decodes and update the cycle after the event.
- Issue FSM, states IDLE, WAIT_DONE, HOLDOFF:
  - IDLE: if fifoEmpty=0, register txByte<=head entry and txDataValid<=1, pop, go to WAIT_DONE. Otherwise stay.
  - WAIT_DONE: txDataValid<=0. On txDone=1, go to HOLDOFF.
  - HOLDOFF: wait for txDone=0, then go to IDLE. This absorbs a multi-cycle done flag and guarantees the transmitter is back at idle before the next launch.
- Latency:
  - Push into an empty queue at cycle N (FSM in IDLE): fifoEmpty=0 at N+1, txDataValid=1 during N+2, exactly one cycle.
  - Back-to-back bytes: next txDataValid occurs 2 cycles after txDone falls (HOLDOFF→IDLE, IDLE→launch).
- txDataValid never asserts outside a single IDLE→WAIT_DONE transition; never two pulses per txDone.
- overflowError: set on a dropped push, cleared on clearOverflow=1. Set has priority over clear in the same cycle.
- queueBusy is combinational: (count != 0) || (state != IDLE).
- txDone=1 observed while in IDLE: ignored.

Decomposition:
- Package uart_pkg holds the issue-FSM state enum (IDLE, WAIT_DONE, HOLDOFF), the default queue depth constant, and the byte typedef shared with the UART transmitter and receiver.
- One sub-module: byte_fifo (DEPTH-parameterised synchronous FIFO providing push, pop, full, empty, count and head-data ports).
- The FSM and overflow logic live in uart_tx_queue.

Test Plan:
- Single byte: reset, push 8'hA5 at cycle 10 → txDataValid=1 only at cycle 12 with txByte=8'hA5. Model txDone high for 2 cycles at cycle 30 → FSM back in IDLE at cycle 33, queueBusy=0.
- Burst of 3: push 8'h31, 8'h32, 8'h33 on consecutive cycles → fifoCount peaks at 2. Three launches in order 31, 32, 33, each exactly 2 cycles after the previous txDone falls, one pulse per byte.
- Fill and overflow (DEPTH=16): push 17 bytes while a transmitter model stalls txDone → fifoFull=1 with count=16, 17th byte dropped, overflowError=1. clearOverflow clears it. The bytes transmitted equal the first 16 in order.
- Wrap-around: push and drain 40 bytes with an incrementing pattern, interleaving pushes during transmission → output sequence equals input sequence, pointers wrap twice, no loss.
- Stretched done: hold txDone high for 5 cycles → no second launch until 2 cycles after txDone falls, even with bytes queued.
- Async reset mid-operation: assert systemResetN=0 while in WAIT_DONE with 4 bytes queued → outputs reach reset values without a clock edge. After release, a txDone pulse causes no launch and fifoEmpty=1.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// uart_pkg: types and constants shared by the UART transmit queue, transmitter and receiver.
package uart_pkg;

   localparam int QUEUE_DEPTH_DEFAULT = 16;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      HOLDOFF   = 2'd2
   } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// uart_tx_queue_if: producer-side queue signals plus the launch/completion handshake to the transmitter.
interface uart_tx_queue_if
   import uart_pkg::*;
#(
   parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) ();

   localparam int COUNT_W = $clog2(DEPTH) + 1;

   logic               writeEnable;
   byte_t              writeByte;
   logic               clearOverflow;
   logic               fifoFull;
   logic               fifoEmpty;
   logic [COUNT_W-1:0] fifoCount;
   logic               overflowError;
   logic               queueBusy;
   logic               txDataValid;
   byte_t              txByte;
   logic               txActive;
   logic               txDone;

   modport slave (
      input  writeEnable, writeByte, clearOverflow, txActive, txDone,
      output fifoFull, fifoEmpty, fifoCount, overflowError, queueBusy, txDataValid, txByte
   );

   modport master (
      output writeEnable, writeByte, clearOverflow, txActive, txDone,
      input  fifoFull, fifoEmpty, fifoCount, overflowError, queueBusy, txDataValid, txByte
   );

endinterface
`default_nettype wire

// File: rtl/uart_tx_queue_byte_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// byte_fifo: power-of-two circular byte buffer; flags and count decode registered state only.
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) (
   input  wire logic                        clk_i,
   input  wire logic                        rst_ni,
   input  wire logic                        push_i,
   input  wire logic                        pop_i,
   input  wire byte_t                       data_i,
   output byte_t                            head_o,
   output logic                             full_o,
   output logic                             empty_o,
   output logic [$clog2(DEPTH):0]           count_o
);

   localparam int AW      = $clog2(DEPTH);
   localparam int COUNT_W = AW + 1;

   byte_t              mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [COUNT_W-1:0] count_q;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign full_o    = (count_q == COUNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign w_push_ok = push_i && !full_o;
   assign w_pop_ok  = pop_i && !empty_o;

   // Pointers are exactly log2(DEPTH) wide so they wrap without explicit compare.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   count_q <= count_q + COUNT_W'(1);
            2'b01:   count_q <= count_q - COUNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`timescale 1ns/1ps
`default_nettype none
// uart_tx_queue: buffers producer bytes and issues them one at a time to the UART transmitter,
// waiting for the transmitter's done flag to rise and fall between launches.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) (
   input  wire logic        systemClock,
   input  wire logic        systemResetN,
   uart_tx_queue_if.slave   bus
);

   localparam int COUNT_W = $clog2(DEPTH) + 1;

   tx_state_e          state_q, state_d;
   byte_t              txByte_q, txByte_d;
   logic               txValid_q, txValid_d;
   logic               overflow_q, overflow_d;
   logic               w_pop;
   byte_t              w_head;
   logic               w_full;
   logic               w_empty;
   logic [COUNT_W-1:0] w_count;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (systemClock),
      .rst_ni  (systemResetN),
      .push_i  (bus.writeEnable),
      .pop_i   (w_pop),
      .data_i  (bus.writeByte),
      .head_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   always_comb begin
      state_d   = state_q;
      txByte_d  = txByte_q;
      txValid_d = 1'b0;
      w_pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_empty) begin
               txByte_d  = w_head;
               txValid_d = 1'b1;
               w_pop     = 1'b1;
               state_d   = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.txDone) state_d = HOLDOFF;
         end
         HOLDOFF: begin
            // A stretched done flag must drop before the next byte may launch.
            if (!bus.txDone) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A dropped push wins over a same-cycle clear so no overflow event is lost.
   always_comb begin
      overflow_d = overflow_q;
      if (bus.writeEnable && w_full) overflow_d = 1'b1;
      else if (bus.clearOverflow)    overflow_d = 1'b0;
   end

   always_ff @(posedge systemClock or negedge systemResetN) begin
      if (!systemResetN) begin
         state_q    <= IDLE;
         txByte_q   <= 8'h00;
         txValid_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         txByte_q   <= txByte_d;
         txValid_q  <= txValid_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.fifoFull      = w_full;
   assign bus.fifoEmpty     = w_empty;
   assign bus.fifoCount     = w_count;
   assign bus.overflowError = overflow_q;
   assign bus.queueBusy     = (w_count != '0) || (state_q != IDLE);
   assign bus.txDataValid   = txValid_q;
   assign bus.txByte        = txByte_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_tx_queue: directed tests with a behavioural transmitter that logs every launch and done edge.
module tb_uart_tx_queue;
   import uart_pkg::*;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   uart_tx_queue_if #(.DEPTH(16)) bus_if ();

   uart_tx_queue #(.DEPTH(16)) u_dut (
      .systemClock  (clk),
      .systemResetN (rst_n),
      .bus          (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model controls and launch log
   logic  stall = 1'b0;
   int    tx_delay = 3;
   int    done_len = 1;
   logic  model_busy = 1'b0;
   byte_t launch_byte [128];
   int    launch_cyc  [128];
   int    fall_cyc    [128];
   int    n_launch = 0;
   int    n_fall = 0;
   int    pulses = 0;
   int    peak = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus_if.txDone   = 1'b0;
      bus_if.txActive = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.txDataValid) begin
            launch_byte[n_launch] = bus_if.txByte;
            launch_cyc[n_launch]  = cyc;
            n_launch++;
            model_busy      = 1'b1;
            bus_if.txActive = 1'b1;
            @(negedge clk);
            check("pulse_width", {31'd0, bus_if.txDataValid}, 32'd0);
            repeat (tx_delay - 1) @(negedge clk);
            while (stall) @(negedge clk);
            bus_if.txDone = 1'b1;
            repeat (done_len) @(negedge clk);
            bus_if.txDone   = 1'b0;
            bus_if.txActive = 1'b0;
            fall_cyc[n_fall] = cyc;
            n_fall++;
            model_busy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus_if.txDataValid) pulses++;
         if (int'(bus_if.fifoCount) > peak) peak = int'(bus_if.fifoCount);
      end
   end

   task automatic push(input byte_t b);
      bus_if.writeEnable = 1'b1;
      bus_if.writeByte   = b;
      @(negedge clk);
      bus_if.writeEnable = 1'b0;
   endtask

   task automatic wait_launches(input int target, input int budget);
      int k = 0;
      while (n_launch < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("launch_timeout", n_launch, target);
   endtask

   task automatic wait_falls(input int target, input int budget);
      int k = 0;
      while (n_fall < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_timeout", n_fall, target);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((bus_if.queueBusy || model_busy) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", {31'd0, bus_if.queueBusy || model_busy}, 32'd0);
   endtask

   initial begin
      int p;
      int lb;
      int fb;
      int p0;

      rst_n                = 1'b0;
      bus_if.writeEnable   = 1'b0;
      bus_if.writeByte     = 8'h00;
      bus_if.clearOverflow = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_empty", {31'd0, bus_if.fifoEmpty}, 32'd1);
      check("rst_full",  {31'd0, bus_if.fifoFull}, 32'd0);
      check("rst_count", {27'd0, bus_if.fifoCount}, 32'd0);
      check("rst_busy",  {31'd0, bus_if.queueBusy}, 32'd0);
      check("rst_valid", {31'd0, bus_if.txDataValid}, 32'd0);
      check("rst_byte",  {24'd0, bus_if.txByte}, 32'd0);
      check("rst_ovf",   {31'd0, bus_if.overflowError}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single byte: launch two cycles after the push cycle, idle one cycle after done falls
      tx_delay = 18;
      done_len = 2;
      p = cyc;
      push(8'hA5);
      check("t1_empty", {31'd0, bus_if.fifoEmpty}, 32'd0);
      check("t1_count", {27'd0, bus_if.fifoCount}, 32'd1);
      wait_launches(1, 20);
      check("t1_latency", launch_cyc[0] - p, 32'd2);
      check("t1_byte", {24'd0, launch_byte[0]}, 32'hA5);
      wait_falls(1, 60);
      while (cyc < fall_cyc[0] + 1) @(negedge clk);
      check("t1_busy", {31'd0, bus_if.queueBusy}, 32'd0);
      check("t1_pulses", pulses, 32'd1);

      // burst of three
      tx_delay = 3;
      done_len = 1;
      peak = 0;
      lb = n_launch;
      fb = n_fall;
      push(8'h31);
      push(8'h32);
      push(8'h33);
      wait_launches(lb + 3, 100);
      wait_falls(fb + 3, 100);
      check("t2_peak", peak, 32'd2);
      for (int i = 0; i < 3; i++)
         check("t2_byte", {24'd0, launch_byte[lb + i]}, 32'h31 + i);
      check("t2_gap0", launch_cyc[lb + 1] - fall_cyc[fb], 32'd2);
      check("t2_gap1", launch_cyc[lb + 2] - fall_cyc[fb + 1], 32'd2);
      check("t2_pulses", pulses, 32'd4);
      wait_idle(50);

      // fill and overflow with the transmitter stalled on a first byte
      stall    = 1'b1;
      tx_delay = 2;
      lb = n_launch;
      push(8'h3F);
      wait_launches(lb + 1, 20);
      for (int i = 0; i < 17; i++) begin
         bus_if.writeEnable = 1'b1;
         bus_if.writeByte   = byte_t'(8'h40 + i);
         @(negedge clk);
      end
      bus_if.writeEnable = 1'b0;
      check("t3_full",  {31'd0, bus_if.fifoFull}, 32'd1);
      check("t3_count", {27'd0, bus_if.fifoCount}, 32'd16);
      check("t3_ovf",   {31'd0, bus_if.overflowError}, 32'd1);
      bus_if.writeEnable   = 1'b1;
      bus_if.writeByte     = 8'h51;
      bus_if.clearOverflow = 1'b1;
      @(negedge clk);
      bus_if.writeEnable   = 1'b0;
      check("t3_set_prio", {31'd0, bus_if.overflowError}, 32'd1);
      @(negedge clk);
      bus_if.clearOverflow = 1'b0;
      check("t3_clear", {31'd0, bus_if.overflowError}, 32'd0);
      stall = 1'b0;
      wait_launches(lb + 17, 400);
      wait_idle(100);
      check("t3_total", n_launch, lb + 17);
      check("t3_first", {24'd0, launch_byte[lb]}, 32'h3F);
      for (int i = 0; i < 16; i++)
         check("t3_order", {24'd0, launch_byte[lb + 1 + i]}, 32'h40 + i);

      // wrap-around: 40 bytes pushed in groups while draining
      tx_delay = 4;
      lb = n_launch;
      for (int g = 0; g < 8; g++) begin
         for (int k = 0; k < 5; k++) push(byte_t'(8'h80 + g * 5 + k));
         repeat (25) @(negedge clk);
      end
      wait_launches(lb + 40, 800);
      for (int i = 0; i < 40; i++)
         check("t4_order", {24'd0, launch_byte[lb + i]}, 32'h80 + i);
      check("t4_ovf", {31'd0, bus_if.overflowError}, 32'd0);
      wait_idle(100);

      // stretched done flag holds off the queued second byte
      tx_delay = 2;
      done_len = 5;
      lb = n_launch;
      fb = n_fall;
      p0 = pulses;
      push(8'hC1);
      push(8'hC2);
      wait_launches(lb + 2, 100);
      wait_falls(fb + 2, 100);
      check("t5_gap", launch_cyc[lb + 1] - fall_cyc[fb], 32'd2);
      check("t5_byte", {24'd0, launch_byte[lb + 1]}, 32'hC2);
      check("t5_pulses", pulses - p0, 32'd2);
      wait_idle(50);

      // asynchronous reset while waiting with four bytes queued
      stall    = 1'b1;
      done_len = 1;
      lb = n_launch;
      for (int i = 0; i < 5; i++) push(byte_t'(8'hD0 + i));
      wait_launches(lb + 1, 20);
      repeat (3) @(negedge clk);
      check("t6_pre_count", {27'd0, bus_if.fifoCount}, 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("t6_count", {27'd0, bus_if.fifoCount}, 32'd0);
      check("t6_empty", {31'd0, bus_if.fifoEmpty}, 32'd1);
      check("t6_busy",  {31'd0, bus_if.queueBusy}, 32'd0);
      check("t6_valid", {31'd0, bus_if.txDataValid}, 32'd0);
      check("t6_byte",  {24'd0, bus_if.txByte}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pulses;
      stall = 1'b0;
      repeat (15) @(negedge clk);
      check("t6_no_launch", pulses - p0, 32'd0);
      check("t6_post_empty", {31'd0, bus_if.fifoEmpty}, 32'd1);
      check("t6_post_busy", {31'd0, bus_if.queueBusy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
